// File: rtl/example_5_3_seq_ctrl.sv
// Sequencing controller for the example 5.3 datapath: owns state register y, replays a pattern RAM.
// Optional expected-z compare is enabled by defining EXAMPLE_5_3_SEQ_CMP_EN.
module example_5_3_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W:0]   len,
  input  logic             pat_we,
  input  logic [CNT_W-1:0] pat_addr,
  input  logic [2:0]       pat_wdata,
  output logic             x1,
  output logic             x2,
  output logic             y,
  input  logic             ny,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step,
  output logic [DEPTH-1:0] resp,
  output logic             mismatch,
  output logic [1:0]       fsm_state
);

`ifdef EXAMPLE_5_3_SEQ_CMP_EN
  localparam int PW = 3;
`else
  localparam int PW = 2;
  logic unused_exp_z;
  assign unused_exp_z = pat_wdata[2];
  assign mismatch = 1'b0;
`endif

  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [PW-1:0]    pat [DEPTH];
  logic [CNT_W-1:0] last_step;
  logic [CNT_W:0]   eff_len;
  logic [CNT_W:0]   eff_m1;
  logic [CNT_W-1:0] step_nx;

  assign fsm_state = state;

  always_comb begin
    eff_len = (len > DEPTH_L) ? DEPTH_L : len;
    eff_m1  = eff_len - {{CNT_W{1'b0}}, 1'b1};
    step_nx = step + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Pattern RAM only accepts writes while idle, so a run always sees a frozen pattern.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
    end else if (pat_we && state == IDLE) begin
      pat[pat_addr] <= pat_wdata[PW-1:0];
    end
  end

  // start is accepted only in IDLE with pat_we low; a write strobe wins over start.
  // done is a one-cycle pulse marking the DONE state; busy covers exactly the RUN cycles.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x1        <= 1'b0;
      x2        <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= '0;
      resp      <= '0;
      last_step <= '0;
`ifdef EXAMPLE_5_3_SEQ_CMP_EN
      mismatch  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !pat_we) begin
            if (len == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              last_step  <= eff_m1[CNT_W-1:0];
              resp       <= '0;
              y          <= 1'b0;
              step       <= '0;
              {x1, x2}   <= pat[0][1:0];
              busy       <= 1'b1;
              state      <= RUN;
`ifdef EXAMPLE_5_3_SEQ_CMP_EN
              mismatch   <= 1'b0;
`endif
            end
          end
        end
        RUN: begin
          resp[step] <= z;
          y          <= ny;
`ifdef EXAMPLE_5_3_SEQ_CMP_EN
          if (z != pat[step][2]) mismatch <= 1'b1;
`endif
          if (step == last_step) begin
            {x1, x2} <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            step     <= step_nx;
            {x1, x2} <= pat[step_nx][1:0];
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_example_5_3_seq_ctrl.sv
// Bench for example_5_3_seq_ctrl: loopback datapath z = x1, ny = x2, queue-based reference model.
module tb_example_5_3_seq_ctrl;
  localparam int DEPTH = 8;
  localparam int CNT_W = 3;

  logic             cp = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W:0]   len = '0;
  logic             pat_we = 1'b0;
  logic [CNT_W-1:0] pat_addr = '0;
  logic [2:0]       pat_wdata = '0;
  logic             x1, x2, y, ny, z, busy, done, mismatch;
  logic [CNT_W-1:0] step;
  logic [DEPTH-1:0] resp;
  logic [1:0]       fsm_state;

  assign z  = x1;
  assign ny = x2;

  example_5_3_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .cp(cp), .rst_n(rst_n), .start(start), .len(len), .pat_we(pat_we),
    .pat_addr(pat_addr), .pat_wdata(pat_wdata), .x1(x1), .x2(x2), .y(y),
    .ny(ny), .z(z), .busy(busy), .done(done), .step(step), .resp(resp),
    .mismatch(mismatch), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 cp = ~cp;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a run is a queue of pending step indices
  logic [2:0]       m_pat [DEPTH];
  int               run_q [$];
  logic             m_y = 1'b0;
  logic             m_done = 1'b0;
  logic             m_mis = 1'b0;
  logic [CNT_W-1:0] m_step = '0;
  logic [DEPTH-1:0] m_resp = '0;
  logic [DEPTH-1:0] exp_q [$];

  initial begin : model
    int idx;
    int n;
    forever begin
      @(posedge cp or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) m_pat[i] = 3'b000;
        run_q.delete();
        m_y = 1'b0; m_done = 1'b0; m_mis = 1'b0; m_step = '0; m_resp = '0;
      end else if (run_q.size() > 0) begin
        idx = run_q.pop_front();
        m_resp[idx] = m_pat[idx][1];
        m_y = m_pat[idx][0];
        if (m_pat[idx][2] != m_pat[idx][1]) m_mis = 1'b1;
        if (run_q.size() > 0) m_step = CNT_W'(run_q[0]);
        else begin
          m_done = 1'b1;
          exp_q.push_back(m_resp);
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (pat_we) begin
        m_pat[pat_addr] = pat_wdata;
      end else if (start) begin
        n = (int'(len) > DEPTH) ? DEPTH : int'(len);
        if (n == 0) begin
          m_done = 1'b1;
          exp_q.push_back(m_resp);
        end else begin
          m_resp = '0; m_mis = 1'b0; m_y = 1'b0; m_step = '0;
          for (int i = 0; i < n; i++) run_q.push_back(i);
        end
      end
    end
  end

  // scoreboard: every cycle compare against the model
  always @(negedge cp) begin : compare
    logic       e_busy;
    logic [1:0] e_x;
    logic       e_mis;
    e_busy = (run_q.size() > 0);
    e_x = e_busy ? m_pat[run_q[0]][1:0] : 2'b00;
`ifdef EXAMPLE_5_3_SEQ_CMP_EN
    e_mis = m_mis;
`else
    e_mis = 1'b0;
`endif
    check("busy", busy, e_busy);
    check("x1x2", {x1, x2}, e_x);
    check("y", y, m_y);
    check("done", done, m_done);
    check("step", step, m_step);
    check("resp", resp, m_resp);
    check("mismatch", mismatch, e_mis);
    if (done) begin
      if (exp_q.size() == 0) check("done_without_expected", 1, 0);
      else check("resp_at_done", resp, exp_q.pop_front());
    end
  end

  // driver tasks: each is entered and left at a falling edge
  task automatic write_pat(input logic [CNT_W-1:0] a, input logic [2:0] d);
    pat_we = 1'b1; pat_addr = a; pat_wdata = d;
    @(negedge cp);
    pat_we = 1'b0;
  endtask

  task automatic run(input int l, input bit disturb, output int bc, output int k);
    bit seen;
    start = 1'b1; len = (CNT_W+1)'(l);
    bc = 0; k = 0; seen = 0;
    while (!seen && k < 24) begin
      @(negedge cp);
      start = 1'b0; pat_we = 1'b0;
      k++;
      if (busy) begin
        bc++;
        if (disturb) begin
          start = 1'($urandom_range(0, 1));
          len = (CNT_W+1)'($urandom_range(0, 15));
          pat_we = 1'($urandom_range(0, 1));
          pat_addr = CNT_W'($urandom_range(0, DEPTH-1));
          pat_wdata = 3'($urandom_range(0, 7));
        end
      end
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
    start = 1'b0; pat_we = 1'b0;
    @(negedge cp);
  endtask

  logic [1:0] tbl [DEPTH];

  task automatic load_table();
    for (int i = 0; i < DEPTH; i++)
      write_pat(CNT_W'(i), {tbl[i][1] ^ (i == 5), tbl[i]});
  endtask

  initial begin
    int bc, k;
    tbl = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    repeat (2) @(negedge cp);
    check("rst_resp", resp, 0);
    check("rst_busy", busy, 0);
    check("rst_x", {x1, x2, y}, 0);
    rst_n = 1'b1;
    @(negedge cp);

    load_table();
    run(8, 0, bc, k);
    check("full_busy_cycles", bc, 8);
    check("full_done_latency", k, 9);
    check("full_resp", resp, 8'h6C);
    check("full_y", y, 0);
`ifdef EXAMPLE_5_3_SEQ_CMP_EN
    check("full_mismatch", mismatch, 1);
`endif

    run(3, 0, bc, k);
    check("len3_busy_cycles", bc, 3);
    check("len3_resp", resp, 8'h04);
    check("len3_step", step, 2);
    check("len3_x", {x1, x2}, 0);
`ifdef EXAMPLE_5_3_SEQ_CMP_EN
    check("len3_mismatch", mismatch, 0);
`endif

    run(0, 0, bc, k);
    check("len0_busy_cycles", bc, 0);
    check("len0_done_latency", k, 1);
    check("len0_resp", resp, 8'h04);

    start = 1'b1; len = 4'd8;
    @(negedge cp);
    start = 1'b0;
    repeat (4) @(negedge cp);
    check("mid_step", step, 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {x1, x2, y, busy, done, mismatch}, 0);
    check("mid_rst_step", step, 0);
    check("mid_rst_resp", resp, 0);
    @(negedge cp);
    rst_n = 1'b1;
    @(negedge cp);
    load_table();
    run(8, 0, bc, k);
    check("after_rst_resp", resp, 8'h6C);

    run(8, 1, bc, k);
    check("disturb_resp", resp, 8'h6C);
    check("disturb_busy_cycles", bc, 8);
    run(8, 0, bc, k);
    check("disturb_pattern_kept", resp, 8'h6C);

    pat_we = 1'b1; pat_addr = '0; pat_wdata = 3'b111; start = 1'b1; len = 4'd8;
    @(negedge cp);
    pat_we = 1'b0; start = 1'b0;
    check("we_start_no_run", busy, 0);
    run(1, 0, bc, k);
    check("we_start_resp", resp, 8'h01);
    check("we_start_y", y, 1);

    for (int it = 0; it < 25; it++) begin
      for (int w = $urandom_range(0, 4); w > 0; w--)
        write_pat(CNT_W'($urandom_range(0, DEPTH-1)), 3'($urandom_range(0, 7)));
      run($urandom_range(0, 15), 1'($urandom_range(0, 1)), bc, k);
    end

    repeat (2) @(negedge cp);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/example_5_3_seq_ctrl.md
# example_5_3_seq_ctrl

Sequencing controller for the example 5.3 synchronous sequential datapath. It owns that circuit's state register `y` and steps the datapath through a programmed sequence of `{x1,x2}` input pairs, one pair per `cp` cycle. It records the `z` output of every step and raises a completion pulse at the end. It replaces the hand-written bench stimulus and `y <= ny` loop, so board and simulation runs share one sequenced drive.

## Interface
Parameters:
- `DEPTH`, 8: number of pattern entries (2..16).
- `CNT_W`, 3: address/step width; `2**CNT_W == DEPTH`.

Ports:
- `cp` input 1: clock, rising-edge active. One clock domain only.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a run; sampled in IDLE only.
- `len` input CNT_W+1: number of steps, 0..DEPTH; sampled at start.
- `pat_we` input 1: pattern write strobe.
- `pat_addr` input CNT_W: pattern write address.
- `pat_wdata` input 3: `{exp_z, x1, x2}`.
- `x1`, `x2` output 1 each: registered datapath inputs.
- `y` output 1: registered datapath state, driven to the datapath `y`.
- `ny` input 1: datapath next-state.
- `z` input 1: datapath output, combinational from the current `x1`, `x2` and `y`.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse in DONE.
- `step` output CNT_W: index of the step currently applied.
- `resp` output DEPTH: captured `z`; bit i holds step i.
- `mismatch` output 1: sticky compare failure.

## Operation
- Pattern RAM: DEPTH x 3 flops. Written on `pat_we` only when not busy; writes during RUN/DONE are dropped.
- FSM states: IDLE, RUN, DONE.
- IDLE, `start=1`, `pat_we=0`:
  - `len==0`: go to DONE directly; no step executes and `resp` is unchanged.
  - `len>0`: latch `eff_len = min(len, DEPTH)`, clear `resp` and `mismatch`, set `y<=0`, `step<=0`, `{x1,x2}<=pat[0][1:0]`, go to RUN.
- IDLE with `start` and `pat_we` both high: the write happens and `start` is ignored.
- RUN, every edge:
  - `resp[step] <= z`.
  - `y <= ny`.
  - If `step == eff_len-1`: `{x1,x2}<=00`, go to DONE.
  - Otherwise: `step <= step+1`, `{x1,x2} <= pat[step+1][1:0]`.
- `start` during RUN/DONE: ignored.
- DONE: `done=1` for one cycle, then IDLE. `y`, `resp`, `mismatch` and `step` hold until the next start.

## Timing
- Reset values: `x1=x2=0`, `y=0`, `busy=0`, `done=0`, `step=0`, `resp=0`, `mismatch=0`; FSM IDLE; pattern RAM cleared to 0.
- `rst_n` low mid-run returns all registers to reset values immediately, with no completion pulse.
- Step i is applied during cycle i after the start edge, and `z` is sampled at the end of that cycle.
- A run of N steps takes N cycles in RUN, plus 1 cycle in DONE, plus 1 cycle back to IDLE. The next `start` is accepted on the cycle `done` is high + 1, i.e. in IDLE.
- `busy` rises on the edge that samples `start` and falls on entry to DONE.
- `step` does not wrap within a run; it stops at `eff_len-1`.

## Configuration
- Macro `EXAMPLE_5_3_SEQ_CMP_EN`.
- Defined:
  - Each RUN edge compares `z` against `pat[step][2]`.
  - Any difference sets `mismatch`, which stays set until the next accepted start or reset.
- Undefined:
  - Bit 2 of `pat_wdata` is not stored; RAM is 2 bits wide.
  - `mismatch` is tied to 0.

## Test plan
Bench loopback: datapath modelled as `z = x1`, `ny = x2`.
- Load pattern 00,01,10,11,01,11,10,00 to addresses 0..7, `len=8`, start -> `busy` high for 8 cycles; `x1x2` follows the pattern one step per cycle; `resp=8'h6C`; `done` pulses once; `y` ends at 0.
- Same pattern, `len=3` -> 3 RUN cycles; `resp=8'h04`; `step` ends at 2; `x1x2=00` after the run.
- `len=0` start -> `done` on the next cycle; `busy` never rises; `resp` unchanged.
- `rst_n` pulsed low at step 4 of an 8-step run -> all outputs 0 immediately; no `done`; a fresh start then works normally.
- `pat_we` and `start` during RUN -> pattern and run unaffected; `start` and `pat_we` together in IDLE -> write lands, no run starts.
- With `EXAMPLE_5_3_SEQ_CMP_EN`: `exp_z` bits set to x1 except step 5 inverted -> `mismatch` rises after step 5 and stays high until the next start.
